// File: rtl/cpu_control.sv
// Initiator-side control unit for the mini-CPU register memory: fetches an instruction
// on a send edge, drives addresses, computes the ALU result and hands it to memory.
module cpu_control #(
    parameter int unsigned READ_LAT      = 1,
    parameter int unsigned STORE_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        power,
    input  logic        send,
    input  logic [15:0] instr,
    input  logic [15:0] v1RAM,
    input  logic [15:0] v2RAM,
    input  logic        stored,
    output logic [2:0]  stateCPU,
    output logic [2:0]  opcode,
    output logic [3:0]  addr1,
    output logic [3:0]  addr2,
    output logic [3:0]  addr3,
    output logic [15:0] valorGuardarRAM,
    output logic [15:0] result,
    output logic [3:0]  disp_addr,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        StOff       = 3'b000,
        StFetch     = 3'b001,
        StDecode    = 3'b010,
        StCalc      = 3'b011,
        StDispStore = 3'b100
    } state_e;

    localparam logic [2:0] OpLoad    = 3'b000;
    localparam logic [2:0] OpAdd     = 3'b001;
    localparam logic [2:0] OpAddi    = 3'b010;
    localparam logic [2:0] OpSub     = 3'b011;
    localparam logic [2:0] OpSubi    = 3'b100;
    localparam logic [2:0] OpMul     = 3'b101;
    localparam logic [2:0] OpClear   = 3'b110;
    localparam logic [2:0] OpDisplay = 3'b111;

    state_e      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic        send_prev_q, send_prev_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  opcode_q, opcode_d;
    logic [3:0]  addr1_q, addr1_d, addr2_q, addr2_d, addr3_q, addr3_d;
    logic [15:0] valor_q, valor_d;
    logic [15:0] result_q, result_d;
    logic [3:0]  disp_addr_q, disp_addr_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [3:0]  dec_a1, dec_a2, dec_a3;
    logic [15:0] imm5_ext;
    logic [15:0] value;

    // Address map decoded straight from the incoming word so it is valid from DECODE on
    always_comb begin
        dec_a1 = '0;
        dec_a2 = '0;
        dec_a3 = '0;
        case (instr[15:13])
            OpLoad, OpDisplay: dec_a1 = instr[12:9];
            OpAdd, OpSub: begin
                dec_a3 = instr[12:9];
                dec_a1 = instr[8:5];
                dec_a2 = instr[4:1];
            end
            OpAddi, OpSubi, OpMul: begin
                dec_a2 = instr[12:9];
                dec_a1 = instr[8:5];
            end
            default: ;
        endcase
    end

    assign imm5_ext = {11'b0, instr_q[4:0]};

    always_comb begin
        value = '0;
        case (instr_q[15:13])
            OpLoad:    value = {7'b0, instr_q[8:0]};
            OpAdd:     value = v1RAM + v2RAM;
            OpAddi:    value = v1RAM + imm5_ext;
            OpSub:     value = v1RAM - v2RAM;
            OpSubi:    value = v1RAM - imm5_ext;
            OpMul:     value = v1RAM * imm5_ext;
            OpClear:   value = '0;
            OpDisplay: value = v1RAM;
            default:   value = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        send_prev_d = send;
        cnt_d       = cnt_q;
        opcode_d    = opcode_q;
        addr1_d     = addr1_q;
        addr2_d     = addr2_q;
        addr3_d     = addr3_q;
        valor_d     = valor_q;
        result_d    = result_q;
        disp_addr_d = disp_addr_q;
        done_d      = 1'b0;
        err_d       = err_q;

        if (!power) begin
            state_d = StOff;
        end else begin
            case (state_q)
                StOff: state_d = StFetch;
                StFetch: begin
                    if (send && !send_prev_q) begin
                        instr_d  = instr;
                        opcode_d = instr[15:13];
                        addr1_d  = dec_a1;
                        addr2_d  = dec_a2;
                        addr3_d  = dec_a3;
                        err_d    = 1'b0;
                        cnt_d    = '0;
                        state_d  = StDecode;
                    end
                end
                StDecode: begin
                    // One cycle to present addresses, then READ_LAT cycles of memory latency
                    if (opcode_q == OpLoad || opcode_q == OpClear || cnt_q == 8'(READ_LAT)) begin
                        cnt_d   = '0;
                        state_d = StCalc;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StCalc: begin
                    valor_d = value;
                    cnt_d   = '0;
                    state_d = StDispStore;
                end
                StDispStore: begin
                    if (opcode_q == OpDisplay || stored) begin
                        result_d    = valor_q;
                        disp_addr_d = (opcode_q == OpClear) ? 4'd0 : instr_q[12:9];
                        done_d      = 1'b1;
                        state_d     = StFetch;
                    end else if (cnt_q == 8'(STORE_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = StFetch;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: state_d = StOff;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StOff;
            instr_q     <= '0;
            send_prev_q <= 1'b0;
            cnt_q       <= '0;
            opcode_q    <= '0;
            addr1_q     <= '0;
            addr2_q     <= '0;
            addr3_q     <= '0;
            valor_q     <= '0;
            result_q    <= '0;
            disp_addr_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            send_prev_q <= send_prev_d;
            cnt_q       <= cnt_d;
            opcode_q    <= opcode_d;
            addr1_q     <= addr1_d;
            addr2_q     <= addr2_d;
            addr3_q     <= addr3_d;
            valor_q     <= valor_d;
            result_q    <= result_d;
            disp_addr_q <= disp_addr_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign stateCPU        = state_q;
    assign opcode          = opcode_q;
    assign addr1           = addr1_q;
    assign addr2           = addr2_q;
    assign addr3           = addr3_q;
    assign valorGuardarRAM = valor_q;
    assign result          = result_q;
    assign disp_addr       = disp_addr_q;
    assign done            = done_q;
    assign err             = err_q;

endmodule
